// File: rtl/matrix_mm_stream_ctrl.sv
`default_nettype none
// ============================================================================
// matrix_mm_stream_ctrl : serial operand loader / result streamer for a 4x4
// combinational matrix multiplier.            Revision: 1.0
// ============================================================================
module matrix_mm_stream_ctrl #(
  parameter int ELEM_W = 3,
  parameter int RES_W  = 8,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ELEM_W-1:0]    in_data,
  output logic [16*ELEM_W-1:0] mat_a,
  output logic [16*ELEM_W-1:0] mat_b,
  input  logic [16*RES_W-1:0]  mm_res,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RES_W-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [4:0]            r_load_cnt;
  logic [WCW-1:0]        r_wait_cnt;
  logic [3:0]            r_out_idx;
  logic [16*ELEM_W-1:0]  r_mat_a;
  logic [16*ELEM_W-1:0]  r_mat_b;
  logic [16*RES_W-1:0]   r_res;
  logic                  w_in_acc;
  logic                  w_out_acc;

  assign w_in_acc  = in_valid  && (r_state == S_LOAD);
  assign w_out_acc = out_ready && (r_state == S_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOAD:  if (w_in_acc && (r_load_cnt == 5'd31)) w_next_state = S_WAIT;
      S_WAIT:  if (r_wait_cnt == '0) w_next_state = S_DRAIN;
      S_DRAIN: if (w_out_acc && (r_out_idx == 4'd15)) w_next_state = S_LOAD;
      default: w_next_state = S_LOAD;
    endcase
  end

  // Counters and operand/result storage; the 5-bit load counter and 4-bit
  // output index wrap to zero on their final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt <= '0;
      r_wait_cnt <= '0;
      r_out_idx  <= '0;
      r_mat_a    <= '0;
      r_mat_b    <= '0;
      r_res      <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_acc) begin
            if (!r_load_cnt[4]) begin
              r_mat_a[r_load_cnt[3:0]*ELEM_W +: ELEM_W] <= in_data;
            end else begin
              r_mat_b[r_load_cnt[3:0]*ELEM_W +: ELEM_W] <= in_data;
            end
            r_load_cnt <= r_load_cnt + 5'd1;
            if (r_load_cnt == 5'd31) begin
              r_wait_cnt <= WCW'(SETTLE - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_res     <= mm_res;
            r_out_idx <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_out_acc) begin
            r_out_idx <= r_out_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == S_LOAD);
    out_valid = (r_state == S_DRAIN);
    out_last  = (r_state == S_DRAIN) && (r_out_idx == 4'd15);
    out_data  = '0;
    if (r_state == S_DRAIN) begin
      out_data = r_res[r_out_idx*RES_W +: RES_W];
    end
    busy      = (r_state != S_LOAD) || (r_load_cnt != 5'd0);
  end

  assign mat_a = r_mat_a;
  assign mat_b = r_mat_b;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mm_stream_ctrl.sv
`default_nettype none
// ============================================================================
// tb_matrix_mm_stream_ctrl : randomized self-checking bench with a behavioural
// 4x4 multiplier and matrix-product reference.  Revision: 1.0
// ============================================================================
module tb_matrix_mm_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_data = 3'd0;
  logic [47:0]  mat_a;
  logic [47:0]  mat_b;
  logic [127:0] mm_res;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic         out_last;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;
  int A [16];
  int B [16];
  int E [16];
  logic [47:0] pa, pb;
  int got;

  always #5 clk = ~clk;

  matrix_mm_stream_ctrl #(.ELEM_W(3), .RES_W(8), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mat_a(mat_a), .mat_b(mat_b), .mm_res(mm_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  // Stand-in for the combinational parallel multiplier
  function automatic logic [127:0] mult(input logic [47:0] a, input logic [47:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 4; k++)
          s += int'(a[(i*4+k)*3 +: 3]) * int'(b[(k*4+j)*3 +: 3]);
        r[(i*4+j)*8 +: 8] = 8'(s);
      end
    return r;
  endfunction

  assign mm_res = mult(mat_a, mat_b);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic prep();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        E[i*4+j] = 0;
        for (int k = 0; k < 4; k++) E[i*4+j] += A[i*4+k] * B[k*4+j];
      end
    for (int k = 0; k < 16; k++) begin
      pa[k*3 +: 3] = A[k][2:0];
      pb[k*3 +: 3] = B[k][2:0];
    end
  endtask

  task automatic fill(input int va, input int vb, input bit rnd);
    for (int k = 0; k < 16; k++) begin
      A[k] = rnd ? int'($urandom_range(0, 7)) : va;
      B[k] = rnd ? int'($urandom_range(0, 7)) : vb;
    end
    prep();
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_mat_a"}, mat_a, 0);
    chk({tag, "_mat_b"}, mat_b, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 rst_check(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the element is accepted
  task automatic put(input int v, input bit hold);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = v[2:0];
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic load_frame(input bit gaps, input bit hold_last);
    for (int k = 0; k < 32; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int q = 0; q < g; q++) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      if (k == 31 && hold_last) put(B[15], 1'b1);
      else put(k < 16 ? A[k] : B[k-16], 1'b0);
      if (k == 31 && hold_last) in_data = 3'd5;
    end
  endtask

  task automatic drain(input int n, input bit rnd, input bit stall34, output int cnt);
    int t;
    int stall_left;
    cnt = 0;
    t = 0;
    stall_left = 5;
    while (cnt < n && t < 2000) begin
      if (out_valid) begin
        chk("out_data", out_data, E[cnt]);
        chk("out_last", out_last, (cnt == 15));
        if (stall34 && cnt == 3 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) cnt++;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    if (t >= 2000) chk("drain_timeout", cnt, n);
  endtask

  task automatic after_frame(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    @(negedge clk);
    pulse_reset("rst0");
    @(negedge clk);

    // Frame 1: reference matrices, fixed latency and known output sequence
    A = '{5,0,2,0, 1,4,5,1, 1,0,6,3, 5,5,3,7};
    B = '{1,5,6,6, 7,6,6,4, 4,4,0,2, 4,6,3,1};
    prep();
    E = '{13,33,30,34, 53,55,33,33, 37,47,15,21, 80,109,81,63};
    load_frame(1'b0, 1'b0);
    chk("lat_wait_valid", out_valid, 0);
    chk("lat_wait_ready", in_ready, 0);
    chk("lat_wait_busy", busy, 1);
    @(negedge clk);
    chk("lat_first_valid", out_valid, 1);
    drain(16, 1'b0, 1'b0, got);
    chk("f1_count", got, 16);
    after_frame("f1");

    // Frame 2: same data, five-cycle stall on the value 34
    load_frame(1'b0, 1'b0);
    drain(16, 1'b0, 1'b1, got);
    chk("f2_count", got, 16);
    after_frame("f2");

    // Frames 3/4: all-7 then back-to-back all-1 with input gaps
    fill(7, 7, 1'b0);
    load_frame(1'b0, 1'b0);
    drain(16, 1'b0, 1'b0, got);
    chk("f3_count", got, 16);
    chk("f3_in_ready_next", in_ready, 1);
    fill(1, 1, 1'b0);
    load_frame(1'b1, 1'b0);
    drain(16, 1'b1, 1'b0, got);
    chk("f4_count", got, 16);
    after_frame("f4");

    // Frame 5: in_valid held high with data 5 through WAIT and DRAIN
    fill(0, 0, 1'b1);
    load_frame(1'b0, 1'b1);
    drain(16, 1'b1, 1'b0, got);
    in_valid = 1'b0;
    chk("f5_count", got, 16);
    chk("f5_mat_a", mat_a, pa);
    chk("f5_mat_b", mat_b, pb);
    after_frame("f5");

    // Frame 6: random data loads correctly afterwards
    fill(0, 0, 1'b1);
    load_frame(1'b1, 1'b0);
    drain(16, 1'b1, 1'b0, got);
    chk("f6_count", got, 16);
    after_frame("f6");

    // Reset after 10 A elements
    fill(0, 0, 1'b1);
    for (int k = 0; k < 10; k++) put(A[k], 1'b0);
    chk("mid_load_busy", busy, 1);
    pulse_reset("rst_load");
    fill(1, 1, 1'b0);
    load_frame(1'b1, 1'b0);
    drain(16, 1'b0, 1'b0, got);
    chk("f7_count", got, 16);
    after_frame("f7");

    // Reset after 6 results drained
    fill(0, 0, 1'b1);
    load_frame(1'b0, 1'b0);
    drain(6, 1'b1, 1'b0, got);
    chk("mid_drain_valid", out_valid, 1);
    pulse_reset("rst_drain");
    fill(1, 1, 1'b0);
    load_frame(1'b0, 1'b0);
    drain(16, 1'b1, 1'b0, got);
    chk("f8_count", got, 16);
    after_frame("f8");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_mm_stream_ctrl.md
# matrix_mm_stream_ctrl

Sequential host-side front end for the team's combinational 4x4 parallel matrix multiplier (3-bit elements, 8-bit results). It accepts a serial stream of 32 operand elements, all of A and then all of B, and holds them on flat operand buses that feed the multiplier. After a programmable settle time it captures the 16 products and streams them back out one per handshake. It replaces a testbench or host driving 32 operand lines and sampling 16 result lines in parallel.

## Interface
- ELEM_W, 3, operand element width.
- RES_W, 8, result element width.
- SETTLE, 1, cycles (>=1) allowed for the multiplier's combinational path before capture.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand element valid.
- in_ready  out  1  block can accept an operand element.
- in_data  in  ELEM_W  operand element, unsigned.
- mat_a  out  16*ELEM_W  A operands; element k=row*4+col at [k*ELEM_W +: ELEM_W]; drives multiplier a00..a33.
- mat_b  out  16*ELEM_W  B operands, same packing; drives b00..b33.
- mm_res  in  16*RES_W  multiplier results res00..res33, same packing at [k*RES_W +: RES_W].
- out_valid  out  1  result element valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  RES_W  result element, unsigned.
- out_last  out  1  high with the 16th result (res33).
- busy  out  1  load in progress or result pending.

## Operation
- States: LOAD, WAIT, DRAIN. Reset enters LOAD with load_cnt=0, wait_cnt=0, out_idx=0. Reset also clears mat_a, mat_b and the result register to 0.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready writes in_data to element load_cnt: 0..15 go to mat_a, 16..31 go to mat_b (index load_cnt-16). load_cnt then increments.
  - Accepting element 31 moves to WAIT with wait_cnt=SETTLE-1 and load_cnt=0.
- WAIT:
  - in_ready=0; wait_cnt decrements each cycle.
  - In the cycle where wait_cnt==0, the edge captures all of mm_res into the result register and moves to DRAIN with out_idx=0.
- DRAIN:
  - out_valid=1; out_data=result[out_idx]; out_last=(out_idx==15).
  - Each out_valid&&out_ready increments out_idx.
  - Handshake with out_last returns to LOAD.
- mat_a and mat_b hold their values across WAIT, DRAIN and the following LOAD until each element is overwritten.
- Arithmetic: no arithmetic in this block. Results pass through unmodified. Maximum legal value is 4*7*7=196, which fits in RES_W=8.
- busy = (state!=LOAD) || (load_cnt!=0).

## Timing
- Reset values:
  - in_ready=1.
  - out_valid=0, out_data=0, out_last=0.
  - mat_a=0, mat_b=0.
  - busy=0.
- in_ready, out_valid, out_data and out_last decode from registered state only. No combinational path exists from in_valid or out_ready to any output.
- Latency with SETTLE=S: element 31 is accepted at the edge ending cycle c. Cycles c+1..c+S are WAIT. out_valid first rises in cycle c+S+1.
- Minimum frame: 32 + S + 16 cycles.
- Backpressure: while out_valid&&!out_ready, out_data, out_idx and out_last hold stable.
- in_valid gaps in LOAD stall load_cnt without loss.
- in_valid outside LOAD is ignored: no write, and load_cnt does not change.
- Input and output phases never overlap, so simultaneous accept and drain cannot occur.
- After the last result handshake, in_ready=1 in the next cycle. Back-to-back frames need no idle cycle.
- Asynchronous reset at any point, including mid-LOAD or mid-DRAIN, immediately forces the reset values. The partial frame is discarded.

## Test plan
Bench instantiates the existing parallel 4x4 multiplier on mat_a, mat_b and mm_res. SETTLE=1 throughout.
- Reset: assert rst_n=0 mid-cycle -> outputs take their reset values immediately (in_ready=1, out_valid=0, out_data=0, out_last=0, mat_a=mat_b=0, busy=0).
- Stream A=[5 0 2 0; 1 4 5 1; 1 0 6 3; 5 5 3 7], then B=[1 5 6 6; 7 6 6 4; 4 4 0 2; 4 6 3 1], with out_ready=1 -> out_valid rises 2 cycles after the last accept. Output sequence: 13,33,30,34,53,55,33,33,37,47,15,21,80,109,81,63, with out_last only on 63.
- Same frame with out_ready=0 for 5 cycles while out_data=34 -> 34 and out_idx hold. Exactly 16 results are delivered, with no duplicate and no drop.
- All-7 frame, then an immediate all-1 frame with random in_valid gaps -> 16x196, then 16x4. in_ready=1 in the cycle after the first out_last.
- in_valid=1 with in_data=5 held through WAIT and DRAIN -> no element accepted; mat_a and mat_b unchanged; the next frame loads correctly.
- Reset after 10 A elements, and separately after 6 results drained -> clean restart. A subsequent all-1 frame yields 16x4.
